vga_scanout: RTL and testbench

//   VGA raster transmitter: derives the 25 MHz pixel tick from I_50MHZ_CLK and sweeps 800x525 timing.

---
 rtl/vga_scanout.sv | 167 ++++++++++++++++
 tb/tb_vga_scanout.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// -----------------------------------------------------------------------------
// vga_scanout
//
// Purpose
//   VGA raster transmitter. A registered divide-by-two of I_50MHZ_CLK gives
//   the pixel clock vga_25clk. Every I_50MHZ_CLK edge on which vga_25clk is
//   high is a pixel tick, and vga_25clk falls on that same edge. All raster
//   state moves only on ticks, so every output is stable at posedge vga_25clk.
//
//   The design is a two-stage pipeline:
//     stage 0 : horizontal/vertical counters, driven directly onto
//               O_PIX_X/O_PIX_Y as the pixel request to the framebuffer.
//     stage 1 : on each tick, registers colour, syncs, display_data and
//               draw_finish for the (h,v) that stage 0 held before the tick.
//   The framebuffer therefore has two I_50MHZ_CLK cycles to answer a request.
//
// Ports
//   I_50MHZ_CLK   in   1   system clock, the only clock
//   I_RESET       in   1   asynchronous, active-high reset
//   O_PIX_X       out  10  column being requested (h counter)
//   O_PIX_Y       out  10  row being requested (v counter)
//   I_PIX_RGB     in   3   {R,G,B} for (O_PIX_X,O_PIX_Y), valid before next tick
//   O_RED/GREEN/BLUE out 1 colour, 0 outside the visible area
//   O_HSYNC       out  1   horizontal sync, SYNC_POL while asserted
//   O_VSYNC       out  1   vertical sync, SYNC_POL while asserted
//   display_data  out  1   the pixel on the output stage is visible
//   draw_finish   out  1   one-tick pulse right after the last visible pixel
//   vga_25clk     out  1   pixel clock, I_50MHZ_CLK / 2, registered
//   O_FRAME_CNT   out  16  completed-frame counter, wraps 65535 -> 0
// -----------------------------------------------------------------------------
module vga_scanout #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        I_50MHZ_CLK,
  input  logic        I_RESET,
  output logic [9:0]  O_PIX_X,
  output logic [9:0]  O_PIX_Y,
  input  logic [2:0]  I_PIX_RGB,
  output logic        O_RED,
  output logic        O_GREEN,
  output logic        O_BLUE,
  output logic        O_HSYNC,
  output logic        O_VSYNC,
  output logic        display_data,
  output logic        draw_finish,
  output logic        vga_25clk,
  output logic [15:0] O_FRAME_CNT
);

  // Raster geometry, sized to the 10-bit counters.
  localparam logic [9:0] L_H_ACTIVE   = 10'(H_ACTIVE);
  localparam logic [9:0] L_H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] L_HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] L_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] L_V_ACTIVE   = 10'(V_ACTIVE);
  localparam logic [9:0] L_V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] L_VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] L_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] L_V_LAST_VIS = 10'(V_ACTIVE - 1);

  // ---------------------------------------------------------------------------
  // Pixel clock and tick
  // ---------------------------------------------------------------------------
  logic r_clk25;
  logic w_tick;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge I_50MHZ_CLK or posedge I_RESET) begin
    if (I_RESET) r_clk25 <= 1'b0;
    else         r_clk25 <= ~r_clk25;
  end

  // The tick is the edge on which vga_25clk falls, leaving a full pixel
  // clock high phase later for downstream logic clocked on posedge vga_25clk.
  assign w_tick = r_clk25;

  // ---------------------------------------------------------------------------
  // Stage 0: raster counters
  // ---------------------------------------------------------------------------
  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       w_h_wrap;
  logic       w_v_wrap;

  assign w_h_wrap = (r_h == L_H_LAST);
  assign w_v_wrap = (r_v == L_V_LAST);

  always_ff @(posedge I_50MHZ_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (w_h_wrap) begin
        r_h <= '0;
        r_v <= w_v_wrap ? '0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: decode of the current (h,v), registered on the tick
  // ---------------------------------------------------------------------------
  logic w_active;
  logic w_hsync_on;
  logic w_vsync_on;
  logic w_frame_end;

  assign w_active    = (r_h < L_H_ACTIVE) && (r_v < L_V_ACTIVE);
  assign w_hsync_on  = (r_h >= L_HS_START) && (r_h < L_HS_END);
  assign w_vsync_on  = (r_v >= L_VS_START) && (r_v < L_VS_END);
  // First position after the last visible pixel of the frame.
  assign w_frame_end = (r_h == L_H_ACTIVE) && (r_v == L_V_LAST_VIS);

  logic [2:0]  r_rgb;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_display;
  logic        r_draw_finish;
  logic [15:0] r_frame_cnt;

  always_ff @(posedge I_50MHZ_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_rgb         <= '0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_display     <= 1'b0;
      r_draw_finish <= 1'b0;
      r_frame_cnt   <= '0;
    end else if (w_tick) begin
      // NOTE: the colour is gated by a mux whose select is always known, so
      // an undriven framebuffer bus during blanking never reaches the pins.
      r_rgb         <= w_active ? I_PIX_RGB : 3'b000;
      r_hsync       <= w_hsync_on ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vsync_on ? SYNC_POL : ~SYNC_POL;
      r_display     <= w_active;
      r_draw_finish <= w_frame_end;
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign vga_25clk    = r_clk25;
  assign O_PIX_X      = r_h;
  assign O_PIX_Y      = r_v;
  assign O_RED        = r_rgb[2];
  assign O_GREEN      = r_rgb[1];
  assign O_BLUE       = r_rgb[0];
  assign O_HSYNC      = r_hsync;
  assign O_VSYNC      = r_vsync;
  assign display_data = r_display;
  assign draw_finish  = r_draw_finish;
  assign O_FRAME_CNT  = r_frame_cnt;

endmodule

// File: tb/tb_vga_scanout.sv
// -----------------------------------------------------------------------------
// tb_vga_scanout
//
// Drives vga_scanout with a reduced raster so several whole frames fit in a
// short run. A framebuffer process answers every pixel request (random junk
// during blanking) and pushes the expected output bundle for that pixel into
// a queue; a monitor pops one entry per pixel clock and compares it with the
// DUT outputs. Expected values come from tick-index arithmetic: tick t after
// reset release shows pixel (t mod HT, (t div HT) mod VT).
// -----------------------------------------------------------------------------
module tb_vga_scanout;

  localparam int HA = 16, HF = 3, HS = 5, HB = 4;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;         // ticks per line
  localparam int VT = VA + VF + VS + VB;         // lines per frame
  localparam int FT = HT * VT;                   // ticks per frame
  localparam int DF_OFF = (VA - 1) * HT + HA;    // tick index of draw_finish

  typedef struct packed {
    logic [2:0]  rgb;
    logic        hs;
    logic        vs;
    logic        de;
    logic        df;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] fc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  pix_rgb = 3'b000;
  logic [9:0]  pix_x, pix_y;
  logic        red, green, blue, hsync, vsync, de, df, clk25;
  logic [15:0] frame_cnt;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .I_50MHZ_CLK (clk),
    .I_RESET     (rst),
    .O_PIX_X     (pix_x),
    .O_PIX_Y     (pix_y),
    .I_PIX_RGB   (pix_rgb),
    .O_RED       (red),
    .O_GREEN     (green),
    .O_BLUE      (blue),
    .O_HSYNC     (hsync),
    .O_VSYNC     (vsync),
    .display_data(de),
    .draw_finish (df),
    .vga_25clk   (clk25),
    .O_FRAME_CNT (frame_cnt)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  obs_t exp_q[$];
  int   n_issued = 0;   // pixels requested since the last reset release
  int   cur_key  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.rgb = {red, green, blue};
    o.hs  = hsync;
    o.vs  = vsync;
    o.de  = de;
    o.df  = df;
    o.x   = pix_x;
    o.y   = pix_y;
    o.fc  = frame_cnt;
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o     = '0;
    o.hs  = 1'b1;
    o.vs  = 1'b1;
    return o;
  endfunction

  // Expected bundle sampled after tick t, with pix the colour the framebuffer
  // supplied for that pixel.
  function automatic obs_t exp_obs(input int t, input logic [2:0] pix);
    obs_t o;
    int h, v, frames;
    logic active;
    h      = t % HT;
    v      = (t / HT) % VT;
    active = (h < HA) && (v < VA);
    frames = (t >= DF_OFF) ? (t - DF_OFF) / FT + 1 : 0;
    o.rgb  = active ? pix : 3'b000;
    o.hs   = !((h >= HA + HF) && (h < HA + HF + HS));
    o.vs   = !((v >= VA + VF) && (v < VA + VF + VS));
    o.de   = active;
    o.df   = (h == HA) && (v == VA - 1);
    o.x    = 10'((t + 1) % HT);
    o.y    = 10'(((t + 1) / HT) % VT);
    o.fc   = 16'(frames);
    return o;
  endfunction

  // Framebuffer / stimulus: answers the request made by the previous tick.
  // Frame 0: (x^y)&7, frame 1: constant 7 everywhere, later: random key.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      n_issued = 0;
    end else if (clk25) begin
      int h, v, fi;
      logic active;
      logic [2:0] pix;
      #1;
      h      = n_issued % HT;
      v      = (n_issued / HT) % VT;
      fi     = n_issued / FT;
      active = (h < HA) && (v < VA);
      if (h == 0 && v == 0) cur_key = int'($urandom_range(0, 7));
      if (fi == 0)      pix = 3'((h ^ v) & 7);
      else if (fi == 1) pix = 3'b111;
      else              pix = 3'((h ^ v ^ cur_key) & 7);
      if (active)       pix_rgb = pix;
      else if (fi == 1) pix_rgb = 3'b111;
      else              pix_rgb = 3'($urandom_range(0, 7));
      exp_q.push_back(exp_obs(n_issued, pix));
      n_issued++;
    end
  end

  // Monitor: one output per pixel clock, sampled mid high phase of vga_25clk.
  int  de_cnt   = 0;
  int  tick_cnt = 0;
  bit  first_df = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      de_cnt   = 0;
      tick_cnt = 0;
      first_df = 1'b1;
    end else if (clk25 && exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      check("pixel_bundle", 64'(dut_obs()), 64'(e));
      tick_cnt++;
      if (de) de_cnt++;
      if (df) begin
        check("visible_per_frame", 64'(de_cnt), 64'(HA * VA));
        check("draw_finish_spacing", 64'(tick_cnt), 64'(first_df ? DF_OFF + 1 : FT));
        de_cnt   = 0;
        tick_cnt = 0;
        first_df = 1'b0;
      end
    end
  end

  task automatic wait_issued(input int target);
    for (int i = 0; i < 2 * target + 100; i++) begin
      @(negedge clk);
      if (n_issued >= target) break;
    end
    check("tick_progress", 64'(n_issued), 64'(target));
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", 64'(dut_obs()), 64'(reset_obs()));
    check("reset_clk25", 64'(clk25), 64'(0));
    #1 rst = 1'b0;

    // Pixel clock phase right after release.
    check("clk25_seq0", 64'(clk25), 64'(0));
    @(posedge clk); #1 check("clk25_seq1", 64'(clk25), 64'(1));
    @(posedge clk); #1 check("clk25_seq2", 64'(clk25), 64'(0));
    check("first_tick", 64'({de, pix_x, pix_y}), 64'({1'b1, 10'd1, 10'd0}));
    @(posedge clk); #1 check("clk25_seq3", 64'(clk25), 64'(1));

    // Several complete frames, then reset mid-frame.
    wait_issued(3 * FT + 2 * HT + 9);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("midframe_reset_outputs", 64'(dut_obs()), 64'(reset_obs()));
    check("midframe_reset_clk25", 64'(clk25), 64'(0));
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Must restart cleanly at pixel (0,0) with a complete first frame.
    wait_issued(2 * FT + 7);
    check("queue_depth", 64'(exp_q.size() <= 1), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
